// File: rtl/sram_dp_arbiter.sv
// Round-robin arbiter sharing a dual-port, one-cycle-read SRAM among NUM_REQ requesters.
// Optional conflict counter output `conflict_cnt` is enabled by defining SRAM_ARB_PERF_EN.
module sram_dp_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_data,
  output logic [ADDR_WIDTH-1:0]            addr_a,
  output logic [ADDR_WIDTH-1:0]            addr_b,
  output logic [DATA_WIDTH-1:0]            data_a,
  output logic [DATA_WIDTH-1:0]            data_b,
  output logic                             we_a,
  output logic                             we_b,
  input  logic [DATA_WIDTH-1:0]            q_a,
  input  logic [DATA_WIDTH-1:0]            q_b
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [15:0]                      conflict_cnt
`endif
);

  localparam int PW = $clog2(NUM_REQ);
  typedef logic [PW-1:0] idx_t;

  function automatic idx_t next_idx(input idx_t i);
    if (i == idx_t'(NUM_REQ - 1)) begin
      return '0;
    end else begin
      return i + idx_t'(1);
    end
  endfunction

  logic [ADDR_WIDTH-1:0] addr_arr_s  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr_s [NUM_REQ];
  idx_t                  scan_s      [NUM_REQ];
  logic [NUM_REQ-1:0]    live_s;
  logic                  a_vld_s, b_vld_s, skip_s;
  idx_t                  a_idx_s, b_idx_s;
  logic [NUM_REQ-1:0]    ready_s;
  logic [NUM_REQ-1:0]    rsp_vld_d, rsp_vld_q;
  logic [NUM_REQ-1:0]    rsp_port_d, rsp_port_q;
  idx_t                  ptr_d, ptr_q;

  // Reset masks every request so no grant or SRAM drive happens while rst is high.
  assign live_s = rst ? '0 : req_valid;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign addr_arr_s[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr_s[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign rsp_data[g*DATA_WIDTH +: DATA_WIDTH] =
      rsp_vld_q[g] ? (rsp_port_q[g] ? q_b : q_a) : '0;
  end

  // Scan order starting at the round-robin pointer.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_s[k] = idx_t'((int'(ptr_q) + k) % NUM_REQ);
    end
  end

  // Port A takes the first live request; port B the next one compatible with A.
  always_comb begin
    a_vld_s = 1'b0;
    b_vld_s = 1'b0;
    a_idx_s = '0;
    b_idx_s = '0;
    skip_s  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (live_s[scan_s[k]]) begin
        if (!a_vld_s) begin
          a_vld_s = 1'b1;
          a_idx_s = scan_s[k];
        end else if (b_vld_s) begin
          skip_s = skip_s;
        end else if ((addr_arr_s[scan_s[k]] != addr_arr_s[a_idx_s]) ||
                     (!req_we[scan_s[k]] && !req_we[a_idx_s])) begin
          b_vld_s = 1'b1;
          b_idx_s = scan_s[k];
        end else begin
          skip_s = 1'b1;
        end
      end else begin
        skip_s = skip_s;
      end
    end
  end

  // Grant vector, pending-response bookkeeping and next pointer.
  always_comb begin
    ready_s    = '0;
    rsp_vld_d  = '0;
    rsp_port_d = '0;
    ptr_d      = ptr_q;
    if (a_vld_s) begin
      ready_s[a_idx_s]   = 1'b1;
      rsp_vld_d[a_idx_s] = !req_we[a_idx_s];
      ptr_d              = next_idx(a_idx_s);
    end else begin
      ptr_d = ptr_q;
    end
    if (b_vld_s) begin
      ready_s[b_idx_s]    = 1'b1;
      rsp_vld_d[b_idx_s]  = !req_we[b_idx_s];
      rsp_port_d[b_idx_s] = 1'b1;
      ptr_d               = next_idx(b_idx_s);
    end else begin
      rsp_port_d = rsp_port_d;
    end
  end

  // SRAM pin drive; an idle port is held at all zeros.
  always_comb begin
    if (a_vld_s) begin
      addr_a = addr_arr_s[a_idx_s];
      data_a = wdata_arr_s[a_idx_s];
      we_a   = req_we[a_idx_s];
    end else begin
      addr_a = '0;
      data_a = '0;
      we_a   = 1'b0;
    end
    if (b_vld_s) begin
      addr_b = addr_arr_s[b_idx_s];
      data_b = wdata_arr_s[b_idx_s];
      we_b   = req_we[b_idx_s];
    end else begin
      addr_b = '0;
      data_b = '0;
      we_b   = 1'b0;
    end
  end

  assign req_ready = ready_s;
  assign rsp_valid = rsp_vld_q;

  // Pointer and read-response tracking registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      rsp_vld_q  <= '0;
      rsp_port_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_port_q <= rsp_port_d;
    end
  end

`ifdef SRAM_ARB_PERF_EN
  logic [15:0] cnt_q;

  // Saturating count of cycles where a request lost out to an address clash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'h0000;
    end else if (skip_s && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign conflict_cnt = cnt_q;
`else
  logic unused_skip_s;
  assign unused_skip_s = skip_s;
`endif

endmodule

// File: tb/tb_sram_dp_arbiter.sv
// Scoreboarded bench for sram_dp_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference of the arbitration rules and an SRAM image.
module tb_sram_dp_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, rsp_data;
  logic [AW-1:0]   addr_a, addr_b;
  logic [DW-1:0]   data_a, data_b, q_a, q_b;
  logic            we_a, we_b;
`ifdef SRAM_ARB_PERF_EN
  logic [15:0]     conflict_cnt;
`endif

  sram_dp_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
    .we_a(we_a), .we_b(we_b), .q_a(q_a), .q_b(q_b)
`ifdef SRAM_ARB_PERF_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Environment SRAM: dual port, registered read.
  logic [DW-1:0] sram_mem [8];
  always @(posedge clk) begin
    if (we_a) sram_mem[addr_a] <= data_a;
    if (we_b) sram_mem[addr_b] <= data_b;
    q_a <= sram_mem[addr_a];
    q_b <= sram_mem[addr_b];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct { int tag; int owner; logic [DW-1:0] data; } exp_t;
  exp_t sbq[$];

  // Reference state
  logic [DW-1:0] ref_mem [8];
  int mptr = 0;
  int mcnt = 0;

  // Stimulus
  bit          sv [N];
  bit          sw [N];
  int          sa [N];
  logic [DW-1:0] sd [N];
  logic [N-1:0]  obs_ready;
  logic          obs_we_a;
  logic [AW-1:0] obs_addr_a;

  task automatic clr_all();
    for (int i = 0; i < N; i++) begin sv[i] = 0; sw[i] = 0; sa[i] = 0; sd[i] = '0; end
  endtask

  task automatic set_req(input int i, input bit w, input int a, input logic [DW-1:0] d);
    sv[i] = 1; sw[i] = w; sa[i] = a; sd[i] = d;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = sv[i];
      req_we[i]    = sw[i];
      req_addr[i*AW +: AW]  = AW'(sa[i]);
      req_wdata[i*DW +: DW] = sd[i];
    end
  endtask

  // One arbitration cycle: apply, check grant and pins, record expected responses.
  task automatic do_cycle();
    int order[$];
    int ga, gb, j;
    bit sk;
    logic [N-1:0] er;
    logic [AW-1:0] ea_a, ea_b;
    logic [DW-1:0] ed_a, ed_b;
    logic ew_a, ew_b;
    apply();
    #2;
    ga = -1; gb = -1; sk = 0;
    for (int k = 0; k < N; k++) begin
      j = (mptr + k) % N;
      if (sv[j]) order.push_back(j);
    end
    foreach (order[x]) begin
      j = order[x];
      if (ga < 0) ga = j;
      else if (gb < 0) begin
        if (sa[j] != sa[ga] || (!sw[j] && !sw[ga])) gb = j;
        else sk = 1;
      end
    end
    er = '0; ea_a = '0; ea_b = '0; ed_a = '0; ed_b = '0; ew_a = 0; ew_b = 0;
    if (ga >= 0) begin er[ga] = 1'b1; ea_a = AW'(sa[ga]); ed_a = sd[ga]; ew_a = sw[ga]; end
    if (gb >= 0) begin er[gb] = 1'b1; ea_b = AW'(sa[gb]); ed_b = sd[gb]; ew_b = sw[gb]; end
    obs_ready = req_ready; obs_we_a = we_a; obs_addr_a = addr_a;
    chk("req_ready", req_ready, er);
    chk("we_a", we_a, ew_a);
    chk("addr_a", addr_a, ea_a);
    chk("data_a", data_a, ed_a);
    chk("we_b", we_b, ew_b);
    chk("addr_b", addr_b, ea_b);
    chk("data_b", data_b, ed_b);
`ifdef SRAM_ARB_PERF_EN
    chk("conflict_cnt", conflict_cnt, mcnt);
`endif
    if (ga >= 0 && !sw[ga]) sbq.push_back('{cyc, ga, ref_mem[sa[ga]]});
    if (gb >= 0 && !sw[gb]) sbq.push_back('{cyc, gb, ref_mem[sa[gb]]});
    if (ga >= 0 && sw[ga]) ref_mem[sa[ga]] = sd[ga];
    if (gb >= 0 && sw[gb]) ref_mem[sa[gb]] = sd[gb];
    if (gb >= 0) mptr = (gb + 1) % N;
    else if (ga >= 0) mptr = (ga + 1) % N;
    if (sk && mcnt < 65535) mcnt++;
    @(negedge clk);
  endtask

  // Steer the pointer by granting its predecessor alone.
  task automatic set_ptr(input int p);
    clr_all();
    set_req((p + N - 1) % N, 0, 0, '0);
    do_cycle();
  endtask

  // Response monitor
  exp_t          e;
  logic [N-1:0]  mon_mask;
  logic [DW-1:0] mon_data [N];
  always @(negedge clk) begin
    #1;
    mon_mask = '0;
    while (sbq.size() > 0 && sbq[0].tag < cyc) begin
      e = sbq.pop_front();
      for (int i = 0; i < N; i++)
        if (e.owner == i && e.tag == cyc - 1) begin mon_mask[i] = 1'b1; mon_data[i] = e.data; end
    end
    chk("rsp_valid", rsp_valid, mon_mask);
    for (int i = 0; i < N; i++)
      if (mon_mask[i]) chk("rsp_data", rsp_data[i*DW +: DW], mon_data[i]);
  end

  int gcount [N];
  logic [DW-1:0] nv;
`ifdef SRAM_ARB_PERF_EN
  int cnt_before;
`endif

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin set_req(i, 1, i, 32'h1111_0000 + i); end
    apply();
    #3;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_rsp_data_nz", {63'b0, |rsp_data}, 64'd0);
    chk("rst_we", {we_a, we_b}, 2'b00);
    chk("rst_addr", {addr_a, addr_b}, 6'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    clr_all();

    // Fill the memory image through requester 0.
    for (int a = 0; a < 8; a++) begin
      clr_all(); set_req(0, 1, a, $urandom); do_cycle();
    end

    // Single requester write then read.
    clr_all(); set_req(0, 1, 5, 32'hDEADBEEF); do_cycle();
    chk("t1_wr_ready", obs_ready, 4'b0001);
    chk("t1_we_a", obs_we_a, 1'b1);
    chk("t1_addr_a", obs_addr_a, 3'd5);
    clr_all(); set_req(0, 0, 5, '0); do_cycle();
    chk("t1_rd_ready", obs_ready, 4'b0001);
    #1;
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_data", rsp_data[DW-1:0], 32'hDEADBEEF);

    // Dual grant from ptr 0, then confirm pointer moved to 3.
    set_ptr(0);
    clr_all(); set_req(0, 0, 1, '0); set_req(2, 0, 6, '0); do_cycle();
    chk("t2_ready", obs_ready, 4'b0101);
    #1;
    chk("t2_rsp_valid", rsp_valid, 4'b0101);
    clr_all(); for (int i = 0; i < N; i++) set_req(i, 0, i, '0); do_cycle();
    chk("t2_ptr3", obs_ready, 4'b1001);

    // Write/read clash on one address.
    set_ptr(1);
`ifdef SRAM_ARB_PERF_EN
    cnt_before = mcnt;
`endif
    nv = 32'hC0FFEE00 ^ $urandom;
    clr_all(); set_req(1, 1, 2, nv); set_req(3, 0, 2, '0); do_cycle();
    chk("t3_ready", obs_ready, 4'b0010);
    clr_all(); set_req(3, 0, 2, '0); do_cycle();
    chk("t3_ready2", obs_ready, 4'b1000);
    #1;
    chk("t3_rsp_data", rsp_data[3*DW +: DW], nv);
`ifdef SRAM_ARB_PERF_EN
    chk("t3_conflict_cnt", conflict_cnt, cnt_before + 1);
`endif

    // Fairness with all four reading distinct addresses.
    set_ptr(0);
    for (int i = 0; i < N; i++) gcount[i] = 0;
    for (int c = 0; c < 8; c++) begin
      clr_all(); for (int i = 0; i < N; i++) set_req(i, 0, i + 2, '0); do_cycle();
      chk("t4_pair", obs_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
      for (int i = 0; i < N; i++) gcount[i] += int'(obs_ready[i]);
    end
    for (int i = 0; i < N; i++) chk("t4_count", gcount[i], 4);

    // Pointer wrap with a shared read address.
    set_ptr(3);
    clr_all(); set_req(3, 0, 7, '0); set_req(0, 0, 7, '0); do_cycle();
    chk("t5_ready", obs_ready, 4'b1001);
    #1;
    chk("t5_rsp_valid", rsp_valid, 4'b1001);
    chk("t5_data0", rsp_data[0 +: DW], ref_mem[7]);
    chk("t5_data3", rsp_data[3*DW +: DW], ref_mem[7]);
    clr_all(); for (int i = 0; i < N; i++) set_req(i, 0, i, '0); do_cycle();
    chk("t5_ptr1", obs_ready, 4'b0110);

    // Randomized traffic.
    for (int c = 0; c < 300; c++) begin
      clr_all();
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) != 0) set_req(i, bit'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom);
      do_cycle();
    end

    // Asynchronous reset while two reads are granted.
    clr_all(); set_req(0, 0, 1, '0); set_req(1, 0, 2, '0); do_cycle();
    apply();
    #2;
    chk("t6_pre_grants", $countones(req_ready), 2);
    rst = 1'b1;
    sbq.delete();
    #1;
    chk("t6_ready", req_ready, 4'b0000);
    chk("t6_we", {we_a, we_b}, 2'b00);
    chk("t6_rsp_valid", rsp_valid, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    mptr = 0; mcnt = 0;
    clr_all(); for (int i = 0; i < N; i++) set_req(i, 0, i, '0); do_cycle();
    chk("t6_ptr0", obs_ready, 4'b0011);
    clr_all(); do_cycle();
    do_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
